// File: rtl/sliced_adder_pkg.sv
// Shared types and helpers for the sliced sequential adder.
package sliced_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD_WRAP = 2'b00,
    MODE_ADD_SAT  = 2'b01,
    MODE_SUB_WRAP = 2'b10,
    MODE_ACC      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Two's-complement overflow from the sign bits of the addends and the result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/slice_add.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module slice_add #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // Plain ripple sum of one slice.
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/sliced_seq_adder.sv
// Multi-cycle adder/subtractor/accumulator processing CHUNK bits per clock
// with a registered carry and valid/ready handshakes on both sides.
module sliced_seq_adder
  import sliced_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             sat_sub,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = $clog2(NSLICE + 1);

  state_e           state;
  mode_e            mode_q;
  mode_e            mode_in;
  logic             sat_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             c_reg;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] a_ld;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;
  logic [CHUNK-1:0] s_slice;
  logic             c_slice;
  logic             last_slice;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_fin;
  logic             carry_fin;
  logic             ovf_fin;

  assign mode_in  = mode_e'(mode);
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  slice_add #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (c_reg),
    .s    (s_slice),
    .cout (c_slice)
  );

  // Operand selection at the accept edge; a clear requested on the same IDLE
  // edge as an ACC accept makes that operation start from zero.
  always_comb begin
    acc_src = ((state == ST_IDLE) && acc_clr) ? '0 : acc;
    a_ld    = a;
    b_ld    = b;
    cin_ld  = 1'b0;
    case (mode_in)
      MODE_ACC: begin
        a_ld = acc_src;
        b_ld = a;
      end
      MODE_SUB_WRAP: begin
        b_ld   = ~b;
        cin_ld = 1'b1;
      end
      default: ;
    endcase
  end

  // Result assembly, final-slice flags and saturation.
  always_comb begin
    last_slice = (idx == CNT_W'(NSLICE - 1));
    res_next   = (res_sh >> CHUNK) | (WIDTH'(s_slice) << (WIDTH - CHUNK));
    carry_fin  = (mode_q == MODE_SUB_WRAP) ? ~c_slice : c_slice;
    ovf_fin    = signed_ovf(a_sh[CHUNK-1], b_sh[CHUNK-1], s_slice[CHUNK-1]);
    sum_fin    = res_next;
    if ((mode_q == MODE_ADD_SAT) && c_slice) begin
      sum_fin = '1;
    end else if ((mode_q == MODE_SUB_WRAP) && sat_q && !c_slice) begin
      sum_fin = '0;
    end
  end

  // Control FSM with operand shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_ADD_WRAP;
      sat_q     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c_reg     <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_clr) begin
            acc <= '0;
          end
          if (accept) begin
            a_sh   <= a_ld;
            b_sh   <= b_ld;
            c_reg  <= cin_ld;
            mode_q <= mode_in;
            sat_q  <= sat_sub;
            idx    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          res_sh <= res_next;
          c_reg  <= c_slice;
          idx    <= idx + 1'b1;
          if (last_slice) begin
            idx       <= '0;
            state     <= ST_DONE;
            out_valid <= 1'b1;
            sum       <= sum_fin;
            carry     <= carry_fin;
            ovf       <= ovf_fin;
            if (mode_q == MODE_ACC) begin
              acc <= res_next;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_sh   <= a_ld;
              b_sh   <= b_ld;
              c_reg  <= cin_ld;
              mode_q <= mode_in;
              sat_q  <= sat_sub;
              idx    <= '0;
              state  <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
